// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared widths and arbiter state encoding for the VGA plot path
package vga_pkg;

  localparam int DEF_X_SZ   = 8;
  localparam int DEF_Y_SZ   = 7;
  localparam int DEF_COL_SZ = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_RELEASE = 2'd2
  } arbState;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin winner select, scanning upward from the engine after lastOwner
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   lastOwner,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  // Walk the ring backwards so the nearest requester after lastOwner overwrites the rest.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(lastOwner) + k) % NUM_REQ);
      if (req[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - session arbiter sharing one registered VGA plot port between engines
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int X_SZ     = DEF_X_SZ,
  parameter int Y_SZ     = DEF_Y_SZ,
  parameter int COL_SZ   = DEF_COL_SZ,
  parameter int HOLD_MAX = 0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         wr,
  input  logic [NUM_REQ*X_SZ-1:0]    x_in,
  input  logic [NUM_REQ*Y_SZ-1:0]    y_in,
  input  logic [NUM_REQ*COL_SZ-1:0]  col_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [X_SZ-1:0]            vga_x,
  output logic [Y_SZ-1:0]            vga_y,
  output logic [COL_SZ-1:0]          vga_col,
  output logic                       vga_plot,
  output logic                       busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  // Saturating at HOLD_LAST keeps the preemption compare true for the rest of a long session.
  localparam logic [CNT_W-1:0] CNT_SAT = (HOLD_MAX > 0) ? HOLD_LAST : {CNT_W{1'b1}};

  arbState          state;
  arbState          nextState;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] lastOwner;
  logic [IDX_W-1:0] winner;
  logic             winValid;
  logic [CNT_W-1:0] holdCnt;
  logic             accept;
  logic             leave;
  logic             otherReq;
  logic [X_SZ-1:0]   selX;
  logic [Y_SZ-1:0]   selY;
  logic [COL_SZ-1:0] selCol;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) uPick (
    .req       (req),
    .lastOwner (lastOwner),
    .winner    (winner),
    .valid     (winValid)
  );

  assign otherReq = |(req & ~gnt);
  assign busy     = (state != ST_IDLE);

  always_comb begin
    selX   = '0;
    selY   = '0;
    selCol = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IDX_W'(i)) begin
        selX   = x_in[i*X_SZ +: X_SZ];
        selY   = y_in[i*Y_SZ +: Y_SZ];
        selCol = col_in[i*COL_SZ +: COL_SZ];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    leave     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (winValid) nextState = ST_OWN;
      end
      ST_OWN: begin
        // A write in the exit cycle still lands because gnt was high when it was offered.
        accept = gnt[owner] & wr[owner];
        leave  = !req[owner] ||
                 ((HOLD_MAX != 0) && (holdCnt == HOLD_LAST) && otherReq);
        if (leave) nextState = ST_RELEASE;
      end
      ST_RELEASE: nextState = ST_IDLE;
      default:    nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt       <= '0;
      owner     <= '0;
      lastOwner <= IDX_W'(NUM_REQ - 1);
      holdCnt   <= '0;
      vga_plot  <= 1'b0;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_col   <= '0;
    end else begin
      vga_plot <= accept;
      if (accept) begin
        vga_x   <= selX;
        vga_y   <= selY;
        vga_col <= selCol;
      end
      case (state)
        ST_IDLE: begin
          if (winValid) begin
            gnt     <= NUM_REQ'(1) << winner;
            owner   <= winner;
            holdCnt <= '0;
          end
        end
        ST_OWN: begin
          if (holdCnt != CNT_SAT) holdCnt <= holdCnt + 1'b1;
          if (leave) begin
            gnt       <= '0;
            lastOwner <= owner;
          end
        end
        default: gnt <= '0;
      endcase
    end
  end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single VGA framebuffer plot port (x, y, colour, plot strobe) between several drawing engines, e.g. the star cleaner, box drawer and star marker.
- Each engine requests a session, receives an exclusive grant, and streams pixel writes.
- The arbiter registers the winning write onto the VGA adapter port.
- Grants rotate round-robin, with an optional hold limit so a long clean cannot starve other engines.

Parameters:
- NUM_REQ, 3, number of requesting engines (2..8).
- X_SZ, 8, x coordinate width.
- Y_SZ, 7, y coordinate width.
- COL_SZ, 3, colour width.
- HOLD_MAX, 0, maximum session length in cycles when another request is pending. 0 disables preemption.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-engine session request, level; held high for the whole session.
- wr  in  NUM_REQ  per-engine pixel write strobe; one pixel per cycle high.
- x_in  in  NUM_REQ*X_SZ  packed x; engine i uses bits [i*X_SZ +: X_SZ].
- y_in  in  NUM_REQ*Y_SZ  packed y, same packing.
- col_in  in  NUM_REQ*COL_SZ  packed colour, same packing.
- gnt  out  NUM_REQ  one-hot grant, registered.
- vga_x  out  X_SZ  registered plot x.
- vga_y  out  Y_SZ  registered plot y.
- vga_col  out  COL_SZ  registered plot colour.
- vga_plot  out  1  registered write enable to the VGA adapter.
- busy  out  1  high in OWN or RELEASE.

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE; gnt=0; vga_plot=0; vga_x/vga_y/vga_col=0; busy=0.
  - last_owner=NUM_REQ-1, so engine 0 wins first; hold_cnt=0.
- States are IDLE, OWN and RELEASE.
- IDLE:
  - If any req bit is high, select the first requester scanning last_owner+1, last_owner+2, ... modulo NUM_REQ.
  - Next cycle: state=OWN, gnt=onehot(winner), owner=winner, hold_cnt=0.
  - No req bits high: stay in IDLE.
- Grant latency: req rising in IDLE gives gnt high on the next edge (1 cycle).
- OWN:
  - Write acceptance: if gnt[owner] and wr[owner] are both high in a cycle, the next edge registers vga_plot=1 and vga_x/vga_y/vga_col from slice owner. Plot latency is 1 cycle.
  - Otherwise vga_plot=0; vga_x/vga_y/vga_col hold their previous values.
  - wr from non-owners is ignored; no error is flagged.
  - hold_cnt increments each OWN cycle and saturates at its maximum.
  - Session exit: req[owner] low, or (HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1 and any other req high). On exit, next state is RELEASE, gnt=0 and last_owner=owner.
- Simultaneous events in OWN:
  - wr[owner] high in the same cycle req[owner] falls: the write is still accepted, because gnt was high.
  - Preemption and a final write in the same cycle: the write is accepted.
- RELEASE: exactly 1 cycle with gnt=0 and no new plots (the final accepted plot may appear this cycle); then IDLE. This guarantees a dead cycle between owners.
- A preempted engine that keeps req high re-enters arbitration normally and regains the grant after the others in round-robin order.
- Grant pattern: gnt is never multi-hot, and is zero in IDLE and RELEASE.
- busy is combinational from state.
- Reset mid-session: all outputs clear immediately, with no partial plot issued.
- Width rule: x, y and colour pass through unmodified; no address translation is done here. The downstream adapter translates (y*160 + x).

Decomposition:
- Shared package vga_pkg holds X_SZ, Y_SZ and COL_SZ defaults, and the state encoding constants ST_IDLE=2'd0, ST_OWN=2'd1, ST_RELEASE=2'd2.
- Sub-module rr_pick (combinational): req vector plus last_owner in, winner index plus valid out.
- The FSM, hold counter and output registers live in vga_plot_arbiter.

Test Plan:
- Single engine: req[1]=1 at cycle 0, then wr[1] for 3 cycles with (x,y,col)=(10,20,3),(11,20,3),(12,20,3).
  - Required: gnt=3'b010 at cycle 1.
  - Required: vga_plot pulses on the 3 cycles after each wr, with exactly those values.
  - Required: after req drop, 1 RELEASE cycle, then IDLE.
- Simultaneous requests from reset: req=3'b111, each held 2 cycles.
  - Required: grant order 0, 1, 2, with gnt=0 for exactly one cycle between owners.
- Non-owner write: while engine 0 owns, wr[2]=1 with (50,50,7).
  - Required: vga_plot is not raised, and vga_x/vga_y/vga_col are unchanged.
- Preemption: HOLD_MAX=4, req[0] held high, req[1] raised at cycle 2.
  - Required: gnt[0] lasts 4 cycles, then RELEASE, then gnt[1].
  - Required: with HOLD_MAX=0 the same stimulus keeps gnt[0] until req[0] drops.
- Last write on release: wr[0]=1 with (5,6,1) in the same cycle req[0] falls.
  - Required: vga_plot=1 with (5,6,1) on the next edge (the RELEASE cycle).
  - Required: no further plots.
- Async reset during OWN: resetn low mid-cycle.
  - Required: gnt, vga_plot and busy drop before the next clk edge.
  - Required: after release, req[2] alone is granted in 1 cycle.
